tank_key_router: RTL and testbench

//  Producer for the tank movement keycode inputs. Scans the 6-slot USB HID keyboard report once per frame.

---
 rtl/tank_key_router.sv | 139 +++++++++++++
 tb/tb_tank_key_router.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tank_key_router.sv
`default_nettype none
// =============================================================================
// Module  : tank_key_router
// Purpose : Turns held HID movement keys into one-frame keycode pulses per tank,
//           with a first-repeat delay and a steady auto-repeat rate.
// Rev     : 1.0
// =============================================================================
module tank_key_router #(
    parameter int REPEAT_DELAY = 15,
    parameter int REPEAT_RATE  = 6
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [47:0] keycodes,
    output logic [7:0]  keycode_p1,
    output logic [7:0]  keycode_p2
);

    localparam int MAX_PERIOD = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW         = $clog2(MAX_PERIOD) + 1;
    localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LOAD  = CW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic          s1_q, s2_q, s3_q;
    logic          tick;
    state_t        state_q [2];
    state_t        state_d [2];
    logic [7:0]    last_q  [2];
    logic [7:0]    last_d  [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [7:0]    out_q   [2];
    logic [7:0]    out_d   [2];
    logic [7:0]    cur     [2];

    function automatic logic in_set(input logic [7:0] code, input logic player);
        if (!player)
            return (code == 8'h04) || (code == 8'h07) || (code == 8'h16) || (code == 8'h1A);
        else
            return (code == 8'h4F) || (code == 8'h50) || (code == 8'h51) || (code == 8'h52);
    endfunction

    // Lowest-index slot holding one of this player's keys wins.
    function automatic logic [7:0] select_key(input logic [47:0] kc, input logic player);
        logic [7:0] result;
        logic       found;
        result = 8'h00;
        found  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!found && in_set(kc[8*i +: 8], player)) begin
                result = kc[8*i +: 8];
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign tick = s2_q & ~s3_q;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            cur[p]     = select_key(keycodes, p[0]);
            state_d[p] = state_q[p];
            last_d[p]  = last_q[p];
            cnt_d[p]   = cnt_q[p];
            out_d[p]   = out_q[p];
            if (tick) begin
                case (state_q[p])
                    ST_IDLE: begin
                        out_d[p] = cur[p];
                        if (cur[p] != 8'h00) begin
                            last_d[p]  = cur[p];
                            cnt_d[p]   = DELAY_LOAD;
                            state_d[p] = ST_DELAY;
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (cur[p] == 8'h00) begin
                            out_d[p]   = 8'h00;
                            state_d[p] = ST_IDLE;
                        end else if (cur[p] != last_q[p]) begin
                            out_d[p]   = cur[p];
                            last_d[p]  = cur[p];
                            cnt_d[p]   = DELAY_LOAD;
                            state_d[p] = ST_DELAY;
                        end else if (cnt_q[p] == '0) begin
                            out_d[p]   = cur[p];
                            cnt_d[p]   = RATE_LOAD;
                            state_d[p] = ST_REPEAT;
                        end else begin
                            out_d[p]   = 8'h00;
                            cnt_d[p]   = cnt_q[p] - CW'(1);
                        end
                    end
                    default: begin
                        out_d[p]   = 8'h00;
                        state_d[p] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= ST_IDLE;
                last_q[p]  <= 8'h00;
                cnt_q[p]   <= '0;
                out_q[p]   <= 8'h00;
            end
        end else begin
            s1_q <= frame_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                last_q[p]  <= last_d[p];
                cnt_q[p]   <= cnt_d[p];
                out_q[p]   <= out_d[p];
            end
        end
    end

    assign keycode_p1 = out_q[0];
    assign keycode_p2 = out_q[1];

endmodule
`default_nettype wire

// File: tb/tb_tank_key_router.sv
`default_nettype none
// =============================================================================
// Module  : tb_tank_key_router
// Purpose : Directed bench for tank_key_router (REPEAT_DELAY=15, REPEAT_RATE=6).
// Rev     : 1.0
// =============================================================================
module tb_tank_key_router;

    logic        Clk;
    logic        Reset_n;
    logic        frame_clk;
    logic [47:0] keycodes;
    logic [7:0]  keycode_p1;
    logic [7:0]  keycode_p2;

    int checks = 0;
    int errors = 0;

    tank_key_router #(
        .REPEAT_DELAY (15),
        .REPEAT_RATE  (6)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .keycodes   (keycodes),
        .keycode_p1 (keycode_p1),
        .keycode_p2 (keycode_p2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full frame: low long enough to re-arm the edge detector, then high
    // past the output-update edge; returns with frame_clk low.
    task automatic tick_frame();
        repeat (3) @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
    endtask

    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        keycodes  = 48'h0000_0000_001A;

        // 1: reset, then idle ticks
        repeat (3) @(negedge Clk);
        chk("rst_p1", keycode_p1, 8'h00);
        chk("rst_p2", keycode_p2, 8'h00);
        keycodes = '0;
        Reset_n  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_frame();
            chk($sformatf("idle_p1_%0d", i), keycode_p1, 8'h00);
            chk($sformatf("idle_p2_%0d", i), keycode_p2, 8'h00);
        end

        // 2: single tap, latency k+2 and one-frame width
        keycodes = 48'h0000_0000_0004;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk("tap_k1", keycode_p1, 8'h00);
        @(negedge Clk);
        chk("tap_k2", keycode_p1, 8'h04);
        frame_clk = 1'b0;
        keycodes  = '0;
        repeat (3) @(negedge Clk);
        chk("tap_hold", keycode_p1, 8'h04);
        tick_frame();
        chk("tap_off", keycode_p1, 8'h00);

        // 3: hold 1A for 40 ticks
        keycodes = 48'h0000_0000_001A;
        for (int i = 0; i < 40; i++) begin
            tick_frame();
            chk($sformatf("hold1A_%0d", i), keycode_p1,
                (i == 0 || (i >= 15 && (i - 15) % 6 == 0)) ? 8'h1A : 8'h00);
        end
        keycodes = '0;
        tick_frame();
        chk("hold1A_rel", keycode_p1, 8'h00);

        // 4: switch key mid-hold restarts the delay
        keycodes = 48'h0000_0000_0007;
        for (int i = 0; i < 10; i++) begin
            tick_frame();
            chk($sformatf("hold07_%0d", i), keycode_p1, (i == 0) ? 8'h07 : 8'h00);
        end
        keycodes = 48'h0000_0000_0016;
        for (int i = 0; i < 16; i++) begin
            tick_frame();
            chk($sformatf("sw16_%0d", i), keycode_p1, (i == 0 || i == 15) ? 8'h16 : 8'h00);
        end
        keycodes = '0;
        tick_frame();

        // 5: both players together, slot priority, independence
        keycodes = {16'h0000, 8'h07, 8'h52, 8'h04, 8'h4F};
        tick_frame();
        chk("both_p1_0", keycode_p1, 8'h04);
        chk("both_p2_0", keycode_p2, 8'h4F);
        for (int i = 1; i < 4; i++) begin
            tick_frame();
            chk($sformatf("both_p1_%0d", i), keycode_p1, 8'h00);
            chk($sformatf("both_p2_%0d", i), keycode_p2, 8'h00);
        end
        keycodes = {16'h0000, 8'h07, 8'h52, 8'h00, 8'h4F};
        tick_frame();
        chk("clr_p1_4", keycode_p1, 8'h07);
        chk("clr_p2_4", keycode_p2, 8'h00);
        for (int i = 5; i < 16; i++) begin
            tick_frame();
            chk($sformatf("ind_p1_%0d", i), keycode_p1, 8'h00);
            chk($sformatf("ind_p2_%0d", i), keycode_p2, (i == 15) ? 8'h4F : 8'h00);
        end
        keycodes = '0;
        tick_frame();
        chk("both_rel_p1", keycode_p1, 8'h00);
        chk("both_rel_p2", keycode_p2, 8'h00);

        // 6: async reset during a hold, then fresh press
        keycodes = 48'h0000_0000_0051;
        for (int i = 0; i < 22; i++) begin
            tick_frame();
            chk($sformatf("hold51_%0d", i), keycode_p2,
                (i == 0 || i == 15 || i == 21) ? 8'h51 : 8'h00);
        end
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1 chk("rst_async_p2", keycode_p2, 8'h00);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick_frame();
            chk($sformatf("fresh51_%0d", i), keycode_p2, (i == 0 || i == 15) ? 8'h51 : 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
